// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response and RAM pins of the memory responder.
// The slave modport is the responder's view; the master modport is the datapath + RAM side.
interface mem_responder_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - registered fetch/load/store responder in front of a single-ported RAM.
// Data requests beat fetches; a RAM access that never completes is abandoned and flagged.
module mem_responder #(
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  mem_responder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, IACC, DACC, RESP, ERR} state_t;
  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      r_state;
  op_t         r_op;
  logic [7:0]  r_cnt;
  logic [31:0] r_iload;
  logic [31:0] r_dload;
  logic        r_ihit;
  logic        r_dhit;
  logic        r_ramREN;
  logic        r_ramWEN;
  logic [31:0] r_ramaddr;
  logic [31:0] r_ramstore;
  logic        r_memerr;

  logic        w_dreq;
  logic [31:0] w_daddr_al;
  logic [31:0] w_iaddr_al;

  assign w_dreq     = bus.dREN | bus.dWEN;
  assign w_daddr_al = bus.daddr & ~32'h3;
  assign w_iaddr_al = bus.iaddr & ~32'h3;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_op       <= OP_FETCH;
      r_cnt      <= '0;
      r_iload    <= '0;
      r_dload    <= '0;
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_ramREN   <= 1'b0;
      r_ramWEN   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_memerr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ihit <= 1'b0;
          r_dhit <= 1'b0;
          // A simultaneous load+store request is served as a store.
          if (w_dreq) begin
            r_state    <= DACC;
            r_op       <= bus.dWEN ? OP_STORE : OP_LOAD;
            r_ramaddr  <= w_daddr_al;
            r_ramstore <= bus.dstore;
            r_ramREN   <= ~bus.dWEN;
            r_ramWEN   <= bus.dWEN;
            r_cnt      <= '0;
          end else if (bus.iREN) begin
            r_state    <= IACC;
            r_op       <= OP_FETCH;
            r_ramaddr  <= w_iaddr_al;
            r_ramstore <= bus.dstore;
            r_ramREN   <= 1'b1;
            r_ramWEN   <= 1'b0;
            r_cnt      <= '0;
          end
        end

        IACC, DACC: begin
          // ramready in the final wait cycle still completes the access.
          if (bus.ramready) begin
            r_state  <= RESP;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            case (r_op)
              OP_FETCH: begin
                r_iload <= bus.ramload;
                r_ihit  <= 1'b1;
              end
              OP_LOAD: begin
                r_dload <= bus.ramload;
                r_dhit  <= 1'b1;
              end
              default: r_dhit <= 1'b1;
            endcase
          end else if (r_cnt == LAST_CNT) begin
            r_state  <= ERR;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            r_memerr <= 1'b1;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        RESP: begin
          r_state <= IDLE;
          r_ihit  <= 1'b0;
          r_dhit  <= 1'b0;
        end

        ERR: r_state <= IDLE;

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;
  assign bus.ihit     = r_ihit;
  assign bus.dhit     = r_dhit;
  assign bus.ramREN   = r_ramREN;
  assign bus.ramWEN   = r_ramWEN;
  assign bus.ramaddr  = r_ramaddr;
  assign bus.ramstore = r_ramstore;
  assign bus.memerr   = r_memerr;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed stimulus with a hit scoreboard for mem_responder.
module tb_mem_responder;
  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  mem_responder_if bus();

  mem_responder #(.TIMEOUT(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        is_fetch;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ihit"},     {31'd0, bus.ihit},   32'd0);
    chk({tag, "_dhit"},     {31'd0, bus.dhit},   32'd0);
    chk({tag, "_ramREN"},   {31'd0, bus.ramREN}, 32'd0);
    chk({tag, "_ramWEN"},   {31'd0, bus.ramWEN}, 32'd0);
    chk({tag, "_memerr"},   {31'd0, bus.memerr}, 32'd0);
    chk({tag, "_iload"},    bus.iload,    32'd0);
    chk({tag, "_dload"},    bus.dload,    32'd0);
    chk({tag, "_ramaddr"},  bus.ramaddr,  32'd0);
    chk({tag, "_ramstore"}, bus.ramstore, 32'd0);
  endtask

  // Monitor: every hit must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST === 1'b0 && (bus.ihit === 1'b1 || bus.dhit === 1'b1)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_hit: ihit=%0b dhit=%0b, expected no hit", bus.ihit, bus.dhit);
      end else begin
        mon_e = sb.pop_front();
        if (bus.ihit !== mon_e.is_fetch || bus.dhit !== !mon_e.is_fetch ||
            (mon_e.is_fetch ? bus.iload : bus.dload) !== mon_e.data) begin
          n_fail++;
          $display("FAIL sb_hit: ihit=%0b dhit=%0b iload=%h dload=%h, expected fetch=%0b data=%h",
                   bus.ihit, bus.dhit, bus.iload, bus.dload, mon_e.is_fetch, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    RST          = 1'b1;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramready = 1'b0;
    repeat (2) next_cycle();
    chk_reset_state("reset");
    RST = 1'b0;

    // Zero-wait fetch
    bus.iREN = 1'b1; bus.iaddr = 32'h43; bus.ramready = 1'b1; bus.ramload = 32'h8C220004;
    sb.push_back('{1'b1, 32'h8C220004});
    next_cycle();
    chk("fetch_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    chk("fetch_ramWEN",  {31'd0, bus.ramWEN}, 32'd0);
    chk("fetch_ramaddr", bus.ramaddr, 32'h40);
    next_cycle();
    chk("fetch_ihit",  {31'd0, bus.ihit}, 32'd1);
    chk("fetch_iload", bus.iload, 32'h8C220004);
    bus.iREN = 1'b0;
    next_cycle();

    // Store beats a simultaneous fetch
    bus.iREN = 1'b1; bus.iaddr = 32'h200;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    bus.ramload = 32'hA5A5A5A5;
    sb.push_back('{1'b0, 32'h0});
    sb.push_back('{1'b1, 32'hA5A5A5A5});
    next_cycle();
    chk("arb_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
    chk("arb_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    chk("arb_ramaddr",  bus.ramaddr, 32'h100);
    chk("arb_ramstore", bus.ramstore, 32'hDEADBEEF);
    next_cycle();
    chk("arb_dhit_c2", {31'd0, bus.dhit}, 32'd1);
    chk("arb_ihit_c2", {31'd0, bus.ihit}, 32'd0);
    bus.dWEN = 1'b0;
    next_cycle();
    chk("arb_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    next_cycle();
    chk("arb_fetch_ramREN",  {31'd0, bus.ramREN}, 32'd1);
    chk("arb_fetch_ramaddr", bus.ramaddr, 32'h200);
    next_cycle();
    chk("arb_ihit_c5", {31'd0, bus.ihit}, 32'd1);
    chk("arb_dload_unchanged", bus.dload, 32'h0);
    bus.iREN = 1'b0;
    next_cycle();

    // Load with four wait cycles
    bus.ramready = 1'b0; bus.dREN = 1'b1; bus.daddr = 32'h304;
    sb.push_back('{1'b0, 32'h12345678});
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      chk("wait_ramREN", {31'd0, bus.ramREN}, 32'd1);
      if (k == 4) begin
        bus.ramready = 1'b1; bus.ramload = 32'h12345678;
      end
    end
    next_cycle();
    chk("wait_dhit",   {31'd0, bus.dhit}, 32'd1);
    chk("wait_dload",  bus.dload, 32'h12345678);
    chk("wait_ramREN_low", {31'd0, bus.ramREN}, 32'd0);
    chk("wait_memerr", {31'd0, bus.memerr}, 32'd0);
    bus.ramready = 1'b0; bus.dREN = 1'b0;
    next_cycle();

    // Timeout: ramready never arrives
    bus.iREN = 1'b1; bus.iaddr = 32'h500;
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      chk("timeout_ramREN", {31'd0, bus.ramREN}, 32'd1);
    end
    next_cycle();
    chk("err_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("err_ihit",   {31'd0, bus.ihit}, 32'd0);
    chk("err_memerr", {31'd0, bus.memerr}, 32'd1);
    bus.iREN = 1'b0;
    next_cycle();
    chk("err_memerr_sticky", {31'd0, bus.memerr}, 32'd1);

    // Reset during the third ACC cycle
    bus.dREN = 1'b1; bus.daddr = 32'h700;
    repeat (3) next_cycle();
    chk("rstmid_ramREN_before", {31'd0, bus.ramREN}, 32'd1);
    RST = 1'b1; bus.dREN = 1'b0;
    next_cycle();
    chk_reset_state("rstmid");
    RST = 1'b0;

    // ramready in the last ACC cycle wins over the timeout
    bus.dREN = 1'b1; bus.daddr = 32'h600; bus.ramload = 32'hCAFEF00D;
    sb.push_back('{1'b0, 32'hCAFEF00D});
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      if (k == 16) begin
        chk("late_ramREN_c16", {31'd0, bus.ramREN}, 32'd1);
        bus.ramready = 1'b1;
      end
    end
    next_cycle();
    chk("late_dhit",   {31'd0, bus.dhit}, 32'd1);
    chk("late_dload",  bus.dload, 32'hCAFEF00D);
    chk("late_memerr", {31'd0, bus.memerr}, 32'd0);
    bus.ramready = 1'b0; bus.dREN = 1'b0;
    next_cycle();

    // Simultaneous load and store is a store
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h803; bus.dstore = 32'h11223344;
    bus.ramready = 1'b1; bus.ramload = 32'h99999999;
    sb.push_back('{1'b0, 32'hCAFEF00D});
    next_cycle();
    chk("ldst_ramWEN",   {31'd0, bus.ramWEN}, 32'd1);
    chk("ldst_ramREN",   {31'd0, bus.ramREN}, 32'd0);
    chk("ldst_ramaddr",  bus.ramaddr, 32'h800);
    chk("ldst_ramstore", bus.ramstore, 32'h11223344);
    next_cycle();
    chk("ldst_dhit", {31'd0, bus.dhit}, 32'd1);
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramready = 1'b0;
    next_cycle();
    chk("ldst_single_dhit_c3", {31'd0, bus.dhit}, 32'd0);
    next_cycle();
    chk("ldst_single_dhit_c4", {31'd0, bus.dhit}, 32'd0);

    repeat (3) next_cycle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Registered memory responder between the datapath's instruction/data request ports and the single-ported RAM. It consumes the `iREN`, `dREN` and `dWEN` requests generated from decoded instructions. It arbitrates them with data priority and drives one RAM access at a time. It returns `ihit`/`dhit` pulses with registered load data, and flags RAM accesses that time out.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum `ACC` cycles spent waiting for `ramready` before the access is abandoned; legal range 2..255.

Ports (all widths are 32-bit `word_t` unless stated otherwise):
- `CLK` in 1: single clock; everything is rising-edge.
- `RST` in 1: reset is synchronous and active-high.
- `iREN` in 1: instruction fetch request.
- `iaddr` in 32: fetch address.
- `iload` out 32: fetched instruction, registered.
- `ihit` out 1: one-cycle fetch-complete pulse.
- `dREN` in 1: data load request.
- `dWEN` in 1: data store request.
- `daddr` in 32: data address.
- `dstore` in 32: store data.
- `dload` out 32: load data, registered.
- `dhit` out 1: one-cycle data-complete pulse.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address; bits [1:0] are always 0.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data; valid when `ramready`=1.
- `ramready` in 1: RAM access complete; one cycle.
- `memerr` out 1: sticky timeout flag.

## Operation
State machine states are `IDLE`, `IACC`, `DACC`, `RESP`, `ERR`. All outputs are registered.

**`IDLE`**
- Samples requests every cycle.
- Data has priority: if `dWEN` or `dREN` is high, the next state is `DACC`; else if `iREN` is high, `IACC`; else stay in `IDLE`.
- On grant:
  - latch the operation, `addr & ~3`, and `dstore`;
  - clear the wait counter.
- `dWEN` and `dREN` both high is treated as a store.

**`IACC` / `DACC`**
- Drive the latched access on the RAM pins:
  - `ramREN`=1 for a fetch or load;
  - `ramWEN`=1 for a store;
  - `ramaddr` and `ramstore` hold their latched values.
- On `ramready`=1:
  - load `ramload` into `iload` (fetch) or `dload` (load); a store leaves `dload` unchanged;
  - the next state is `RESP`.
- Otherwise the counter increments. When the counter equals `TIMEOUT-1` and `ramready`=0, the next state is `ERR`.

**`RESP`**
- Lasts one cycle.
- `ihit`=1 for a fetch; `dhit`=1 for a load or store.
- RAM strobes are low.
- The next state is always `IDLE`.
- The requester updates or drops its request at the end of this cycle, so no request is served twice.

**`ERR`**
- Lasts one cycle.
- Strobes are low; no hit is issued.
- `memerr` is set and stays set until `RST`.
- The next state is `IDLE`. The still-pending request is re-arbitrated normally.

**Protocol rules**
- A requester holds its request and address stable until its hit.
- Request changes during `IACC`/`DACC` are ignored; the latched values govern the access.
- A pending `iREN` waits while data requests keep winning. No fairness is provided; this is intended.

## Timing
- Reset values:
  - state is `IDLE`;
  - `ihit`, `dhit`, `ramREN`, `ramWEN`, `memerr` are 0;
  - `iload`, `dload`, `ramaddr`, `ramstore` are 0;
  - the counter is 0.
- `RST` in any state, including mid-access, forces the reset values at the next edge. The RAM strobes drop on that edge.
- Latency with a request sampled in `IDLE` at cycle 0:
  - cycle 1 is the first `ACC` cycle, with strobes high;
  - with `ramready` arriving at `ACC` cycle n (n≥1), the hit is high at cycle n+1;
  - the minimum request-to-hit latency is 2 cycles.
- Back-to-back throughput is one access per 3 cycles (`IDLE`, `ACC`, `RESP`) with a zero-wait RAM.
- `ramready` is ignored outside `ACC`.
- Timeout: with no `ramready`, `ACC` lasts exactly `TIMEOUT` cycles, then there is one `ERR` cycle.
  - `memerr` rises at the first edge after the last `ACC` cycle.
  - A `ramready` arriving in the last `ACC` cycle wins over the timeout, and no error is raised.
- `iload`/`dload` update on the edge entering `RESP` and are stable while the hit is high.
- The counter is 8 bits and saturates; it never wraps.

## Test plan
- **Zero-wait fetch:** `iREN`=1, `iaddr`=0x00000043, `ramready` high in the first `ACC` cycle with `ramload`=0x8C220004. Required: `ramREN`=1 and `ramaddr`=0x00000040 at cycle 1; `ihit`=1 with `iload`=0x8C220004 at cycle 2.
- **Arbitration, zero-wait RAM:** `iREN`=1 and `dWEN`=1 in the same cycle, `daddr`=0x100, `dstore`=0xDEADBEEF. Required:
  - the store is served first, with `ramWEN`=1, `ramaddr`=0x100, `ramstore`=0xDEADBEEF, and `dhit` at cycle 2;
  - the fetch is sampled at cycle 3 and `ihit` pulses at cycle 5;
  - `dload` is unchanged.
- **Wait states:** a load with `ramready` after 4 `ACC` cycles and `ramload`=0x12345678. Required: strobes are held for 4 cycles, then `dhit`=1 with `dload`=0x12345678; `memerr` stays 0.
- **Timeout:** `TIMEOUT`=16 and `ramready` tied low. Required: `ramREN` is high for exactly 16 cycles, then one `ERR` cycle with no hit; `memerr`=1 and stays 1.
  - A repeat with `ramready` pulsed in `ACC` cycle 16 gives `dhit` and `memerr`=0.
- **Reset mid-access:** assert `RST` during the third `ACC` cycle. Required: at the next edge all outputs are 0, including `memerr` and `ramREN`. After `RST` drops, a new request completes normally.
- **Simultaneous load and store:** `dREN`=`dWEN`=1. Required: a store is performed (`ramWEN`=1, `ramREN`=0), followed by a single `dhit`.
